// File: rtl/cpu_bus_pkg.sv
// Shared state type, timeout default and region ordering for the 68000 bus cycle controller.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT,
        EXT,
        ACK,
        NOSEL,
        BERR,
        DRAIN
    } bus_state_t;

    localparam int unsigned BUS_TIMEOUT_DEFAULT = 1023;

    // Select ordering from the address translator; lower index wins.
    localparam int unsigned REGION_ROM   = 0;
    localparam int unsigned REGION_WORK  = 1;
    localparam int unsigned REGION_VRAM  = 2;
    localparam int unsigned REGION_PAL   = 3;
    localparam int unsigned REGION_IO    = 4;
    localparam int unsigned REGION_SOUND = 5;

    function automatic logic bus_start(input logic as_n, input logic [1:0] ds_n);
        return !as_n && !(&ds_n);
    endfunction

endpackage

// File: rtl/bus_region_prio_enc.sv
// Lowest-index-wins priority encoder over the active-low region selects.
module bus_region_prio_enc
    import cpu_bus_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_REGIONS)
) (
    input  logic [NUM_REGIONS-1:0] sel_n,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    // Scan from the top so the lowest asserted index is the last to write.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            if (!sel_n[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_bus_cycle_ctrl.sv
// Sequences each 68000 bus cycle: wait states or req/ack handshake, then DTACKn or BERRn.
// Optional statistics counters are enabled with CPU_BUS_STATS_EN.
module cpu_bus_cycle_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 16,
    parameter int unsigned WAIT_W      = 4,
    parameter int unsigned TIMEOUT_CYC = BUS_TIMEOUT_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             ce_cpu,
    input  logic                             cpu_as_n,
    input  logic [1:0]                       cpu_ds_n,
    input  logic [NUM_REGIONS-1:0]           sel_n,
    input  logic [NUM_REGIONS*WAIT_W-1:0]    wait_cfg,
    input  logic [NUM_REGIONS-1:0]           ext_mask,
    output logic                             mem_req,
    input  logic                             mem_ack,
    output logic [$clog2(NUM_REGIONS)-1:0]   mem_region,
    output logic                             cpu_dtack_n,
    output logic                             cpu_berr_n,
    output logic                             busy
`ifdef CPU_BUS_STATS_EN
    ,
    output logic [31:0]                      stat_cycles,
    output logic [31:0]                      stat_wait_clks,
    output logic [15:0]                      stat_berr
`endif
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGIONS);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = {TCNT_W{1'b1}};

    bus_state_t          state_q, state_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [IDX_W-1:0]    region_q, region_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                req_q, req_d;
    logic                drain_berr_q, drain_berr_d;
    logic                dtack_n_q, berr_n_q;

    logic                enc_valid;
    logic [IDX_W-1:0]    enc_idx;
    logic [WAIT_W-1:0]   enc_wait;
    logic                enc_ext;
    logic                start;
    logic                ack_match;
    logic                timed_out;

    bus_region_prio_enc #(
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W)
    ) u_prio_enc (
        .sel_n (sel_n),
        .valid (enc_valid),
        .index (enc_idx)
    );

    assign enc_wait  = wait_cfg[enc_idx*WAIT_W +: WAIT_W];
    assign enc_ext   = ext_mask[enc_idx];
    assign start     = bus_start(cpu_as_n, cpu_ds_n);
    assign ack_match = (mem_ack == req_q);
    assign timed_out = (tcnt_q >= TCNT_LAST);

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        region_d     = region_q;
        req_d        = req_q;
        drain_berr_d = drain_berr_q;
        // Saturating so a long ACK/BERR hold never wraps back below the limit.
        tcnt_d       = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (start) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!enc_valid) begin
                    state_d = NOSEL;
                end else begin
                    region_d = enc_idx;
                    wcnt_d   = enc_wait;
                    if (enc_ext) begin
                        req_d   = ~req_q;
                        state_d = EXT;
                    end else if (enc_wait == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    state_d = BERR;
                end else if (ce_cpu) begin
                    if (wcnt_q == WAIT_W'(1)) begin
                        state_d = ACK;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
            end
            EXT: begin
                if (ack_match) begin
                    state_d = cpu_as_n ? IDLE : ACK;
                end else if (cpu_as_n) begin
                    drain_berr_d = 1'b0;
                    state_d      = DRAIN;
                end else if (timed_out) begin
                    drain_berr_d = 1'b1;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (ack_match) begin
                    state_d = drain_berr_q ? BERR : IDLE;
                end
            end
            NOSEL: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    state_d = BERR;
                end else if (enc_valid) begin
                    state_d = SETTLE;
                end
            end
            ACK: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end
            end
            BERR: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            region_q     <= '0;
            tcnt_q       <= '0;
            req_q        <= 1'b0;
            drain_berr_q <= 1'b0;
            dtack_n_q    <= 1'b1;
            berr_n_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            region_q     <= region_d;
            tcnt_q       <= tcnt_d;
            req_q        <= req_d;
            drain_berr_q <= drain_berr_d;
            // Strobes follow the state one clk late and drop on the same edge AS is seen high.
            dtack_n_q    <= !((state_q == ACK) && !cpu_as_n);
            berr_n_q     <= !((state_q == BERR) && !cpu_as_n);
        end
    end

    assign mem_req     = req_q;
    assign mem_region  = region_q;
    assign cpu_dtack_n = dtack_n_q;
    assign cpu_berr_n  = berr_n_q;
    assign busy        = (state_q != IDLE);

`ifdef CPU_BUS_STATS_EN
    logic ack_entry;
    logic berr_entry;
    logic stall_clk;

    assign ack_entry  = (state_d == ACK) && (state_q != ACK);
    assign berr_entry = (state_d == BERR) && (state_q != BERR);
    assign stall_clk  = (state_q == WAIT) || (state_q == EXT) || (state_q == NOSEL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_cycles    <= '0;
            stat_wait_clks <= '0;
            stat_berr      <= '0;
        end else begin
            if (ack_entry) begin
                stat_cycles <= stat_cycles + 1'b1;
            end
            if (stall_clk) begin
                stat_wait_clks <= stat_wait_clks + 1'b1;
            end
            if (berr_entry) begin
                stat_berr <= stat_berr + 1'b1;
            end
        end
    end
`else
    // Statistics counters compiled out; bus behaviour is unchanged.
`endif

endmodule
